axi_stream_remove_header: RTL and testbench
===========================================

Name: axi_stream_remove_header

Overview:
- Downstream companion of the header-insertion stage. Strips the first N bytes (N = 0..4) of each AXI-Stream packet and presents them on a separate header channel.
- Re-aligns the remaining payload bytes MSB-first into dense 32-bit beats on the master stream.
- Sits directly after the insert stage, for example in loopback and checker paths, to recover header and payload.

Parameters:
- DATA_WD, 32, stream data width in bits.
- DATA_BYTE_WD, 4, bytes per beat (DATA_WD/8); keep width.
- BYTE_CNT_WD, 3, width of byte_remove_cnt.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- valid_in  in  1  slave beat valid
- data_in  in  DATA_WD  slave data; byte 0 = data_in[31:24] is the first byte in stream order
- keep_in  in  DATA_BYTE_WD  byte enables; contiguous from MSB; 4'b1111 on all non-last beats (upstream requirement)
- last_in  in  1  final beat of packet
- ready_in  out  1  slave ready
- byte_remove_cnt  in  BYTE_CNT_WD  header length N; sampled on the first beat of each packet; values >4 clamp to 4
- valid_hdr  out  1  header beat valid
- data_hdr  out  DATA_WD  header bytes MSB-aligned; unused bytes 0
- keep_hdr  out  DATA_BYTE_WD  header byte enables, MSB-aligned
- ready_hdr  in  1  header consumer ready
- valid_out  out  1  payload beat valid
- data_out  out  DATA_WD  payload data MSB-aligned; unused bytes 0
- keep_out  out  DATA_BYTE_WD  payload enables; 4'b1111 except possibly on the last beat
- last_out  out  1  final payload beat
- ready_out  in  1  payload consumer ready

Behaviour:
- Reset:
  - Asynchronous on rst high: state HEAD; valid_hdr=0, valid_out=0, last_out=0; all data and keep outputs 0; residue count 0.
  - ready_in=0 while rst is high.
- Handshake and outputs:
  - A transfer occurs when valid && ready on a rising clk edge.
  - All hdr/out channel outputs are registered.
  - Each output register holds its value stable while valid && !ready.
- ready_in:
  - Equals out_free && hdr_free && (state != FLUSH), where out_free = !valid_out || ready_out and hdr_free = !valid_hdr || ready_hdr.
  - ready_in may depend combinationally on ready_out/ready_hdr; it has no path from valid_in.
- Header channel:
  - Loaded only in HEAD.
  - data_hdr = first min(N,k) bytes of the first beat (k = byte count of keep_in); keep_hdr has that many MSB ones.
  - No header beat when N=0.
- State HEAD (first beat accepted, N sampled):
  - last_in=1: P = k−N payload bytes. If P>0, emit one beat of those bytes shifted to the MSB, with last_out=1 and keep of P ones. If P≤0, emit no payload beat. Stay in HEAD.
  - N=0: emit the beat unchanged (last_out=0); residue R=0; go to BODY.
  - N=4: emit no payload beat; R=0; go to BODY.
  - N=1..3: hold bytes N..3 in the residue register; R=4−N; no payload beat yet; go to BODY.
- State BODY (beat with k bytes accepted):
  - The combined stream is residue(R) followed by beat(k).
  - Non-last: emit the first 4 bytes; the remaining R bytes become the new residue.
  - Last with R+k≤4: emit the combined bytes with last_out=1 and keep of R+k ones; go to HEAD.
  - Last with R+k>4: emit the first 4 bytes; residue becomes R+k−4; go to FLUSH.
- State FLUSH:
  - Emit the residue with last_out=1 and keep of R ones; ready_in=0.
  - On accept, clear the residue and go to HEAD.
- Latency and throughput:
  - Latency is 1 cycle from the accepting input edge to valid_out/valid_hdr, with no backpressure.
  - Full throughput of 1 beat/cycle when ready_out=ready_hdr=1; FLUSH costs 1 input bubble.
- byte_remove_cnt changes mid-packet are ignored.
- Reset mid-packet discards the residue and any pending header/payload beats; the next accepted beat is treated as a packet start.

Decomposition:
- Shared package axi_stream_pkg:
  - Constants DATA_WD, DATA_BYTE_WD, BYTE_CNT_WD.
  - State enum {HEAD, BODY, FLUSH}.
  - Function keep2cnt (MSB-contiguous keep → byte count).
  - Function cnt2keep (byte count → MSB-contiguous keep).
- One natural sub-module: axi_stream_byte_shifter, a combinational merge of residue and beat by R, producing {out_word, out_keep, new_residue, new_R}.

Test Plan:
- N=2; beats 0xA1A2A3A4/1111, 0xB1B2B3B4/1111, 0xC1C20000/1100 last → hdr 0xA1A20000/1100; out 0xA3A4B1B2/1111, then 0xB3B4C1C2/1111 last; no FLUSH.
- N=1; same first two beats, last 0xC1C2C300/1110 → hdr 0xA1000000/1000; out 0xA2A3A4B1, 0xB2B3B4C1, then 0xC2C30000/1100 last (FLUSH, ready_in=0 for 1 cycle).
- N=4; single beat 0x11223344/1111 last → hdr 0x11223344/1111; no payload beat. byte_remove_cnt=3'b111 gives the same result (clamp).
- N=0; 3-beat packet with last 0xDEAD0000/1100 → no hdr beat; out equals input delayed 1 cycle, last_out on 0xDEAD0000/1100.
- Backpressure: N=2 stream with ready_out low for 3 cycles mid-packet → data_out/keep_out stable, ready_in=0, no byte lost or duplicated. ready_hdr low on packet start → ready_in=0 until the header is taken.
- rst pulsed during BODY of an N=1 packet → all valids 0 immediately; a following N=0 packet 0x01020304 last passes through unchanged.

Source files
------------

// File: rtl/axi_stream_pkg.sv
// Shared types, constants and byte-count helpers for the AXI-Stream header
// removal path.
//
// Contents:
//   DATA_WD, DATA_BYTE_WD, BYTE_CNT_WD  stream geometry
//   RES_WD                              residue width (one byte less than a beat)
//   BEAT_BYTES                          bytes per beat as a count-width value
//   state_e                             HEAD / BODY / FLUSH
//   keep2cnt, cnt2keep, keep2mask       MSB-contiguous keep helpers
package axi_stream_pkg;

  localparam int unsigned DATA_WD      = 32;
  localparam int unsigned DATA_BYTE_WD = DATA_WD / 8;
  localparam int unsigned BYTE_CNT_WD  = 3;

  // The residue never holds a full beat, so one byte less is enough.
  localparam int unsigned RES_WD = DATA_WD - 8;

  localparam logic [BYTE_CNT_WD-1:0] BEAT_BYTES = BYTE_CNT_WD'(DATA_BYTE_WD);

  typedef enum logic [1:0] {
    HEAD,
    BODY,
    FLUSH
  } state_e;

  // Number of enabled bytes in an MSB-contiguous keep.
  function automatic logic [BYTE_CNT_WD-1:0] keep2cnt(input logic [DATA_BYTE_WD-1:0] keep);
    logic [BYTE_CNT_WD-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      cnt = cnt + BYTE_CNT_WD'(keep[i]);
    end
    return cnt;
  endfunction

  // MSB-contiguous keep with cnt ones.
  function automatic logic [DATA_BYTE_WD-1:0] cnt2keep(input logic [BYTE_CNT_WD-1:0] cnt);
    logic [DATA_BYTE_WD-1:0] keep;
    keep = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      keep[DATA_BYTE_WD-1-i] = (BYTE_CNT_WD'(i) < cnt);
    end
    return keep;
  endfunction

  // Expand byte enables into a bit mask.
  function automatic logic [DATA_WD-1:0] keep2mask(input logic [DATA_BYTE_WD-1:0] keep);
    logic [DATA_WD-1:0] mask;
    mask = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      mask[8*i +: 8] = {8{keep[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/axi_stream_byte_shifter.sv
// Combinational merge of a residue (res_cnt bytes, MSB-aligned) with an
// incoming beat (MSB-contiguous keep). The combined byte stream is residue
// followed by beat; the first DATA_BYTE_WD bytes form out_word, the rest
// become the new residue.
//
// Ports:
//   res_data, res_cnt    current residue bytes (unused bytes must be 0) and count
//   beat_data, beat_keep incoming beat and its byte enables
//   out_word, out_keep   first beat worth of combined bytes, unused bytes 0
//   new_res, new_cnt     bytes left over after out_word
//   total_cnt            residue + beat byte count
module axi_stream_byte_shifter
  import axi_stream_pkg::*;
(
  input  logic [RES_WD-1:0]       res_data,
  input  logic [BYTE_CNT_WD-1:0]  res_cnt,
  input  logic [DATA_WD-1:0]      beat_data,
  input  logic [DATA_BYTE_WD-1:0] beat_keep,
  output logic [DATA_WD-1:0]      out_word,
  output logic [DATA_BYTE_WD-1:0] out_keep,
  output logic [RES_WD-1:0]       new_res,
  output logic [BYTE_CNT_WD-1:0]  new_cnt,
  output logic [BYTE_CNT_WD-1:0]  total_cnt
);

  localparam int unsigned CombWd = DATA_WD + RES_WD;

  logic [CombWd-1:0]      res_ext;
  logic [CombWd-1:0]      beat_ext;
  logic [CombWd-1:0]      comb_word;
  logic [BYTE_CNT_WD-1:0] beat_cnt;

  always_comb begin
    beat_cnt  = keep2cnt(beat_keep);
    total_cnt = res_cnt + beat_cnt;

    // Place the residue at the top and slide the masked beat down behind it.
    res_ext   = {res_data, {DATA_WD{1'b0}}};
    beat_ext  = {beat_data & keep2mask(beat_keep), {RES_WD{1'b0}}} >> {res_cnt, 3'b000};
    comb_word = res_ext | beat_ext;

    out_word = comb_word[CombWd-1 -: DATA_WD];
    new_res  = comb_word[RES_WD-1:0];

    if (total_cnt > BEAT_BYTES) begin
      out_keep = '1;
      new_cnt  = total_cnt - BEAT_BYTES;
    end else begin
      out_keep = cnt2keep(total_cnt);
      new_cnt  = '0;
    end
  end

endmodule

// File: rtl/axi_stream_remove_header.sv
// Strips the first N (0..4) bytes of each AXI-Stream packet onto a separate
// header channel and re-packs the remaining payload densely, MSB-first, onto
// the master stream.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   valid_in, data_in, keep_in,
//   last_in, ready_in                 slave stream (ready_in is an output)
//   byte_remove_cnt                   header length, sampled on packet start,
//                                     values above 4 clamp to 4
//   valid_hdr, data_hdr, keep_hdr,
//   ready_hdr                         header channel (one beat per packet, N>0)
//   valid_out, data_out, keep_out,
//   last_out, ready_out               payload master stream
// All hdr/out outputs are registered and held while valid && !ready.
module axi_stream_remove_header
  import axi_stream_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,

  input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,

  output logic                    valid_hdr,
  output logic [DATA_WD-1:0]      data_hdr,
  output logic [DATA_BYTE_WD-1:0] keep_hdr,
  input  logic                    ready_hdr,

  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
);

  state_e                  state_q, state_d;
  logic [RES_WD-1:0]       res_q, res_d;
  logic [BYTE_CNT_WD-1:0]  res_cnt_q, res_cnt_d;

  logic                    out_free, hdr_free, fire;

  // Packet-start decode.
  logic [BYTE_CNT_WD-1:0]  n_clamp;
  logic [BYTE_CNT_WD-1:0]  in_cnt;
  logic [BYTE_CNT_WD-1:0]  hdr_cnt;
  logic [BYTE_CNT_WD-1:0]  pay_cnt;
  logic [DATA_WD-1:0]      in_masked;
  logic [DATA_WD-1:0]      head_shifted;

  // Residue merge.
  logic [DATA_WD-1:0]      sh_word;
  logic [DATA_BYTE_WD-1:0] sh_keep;
  logic [RES_WD-1:0]       sh_res;
  logic [BYTE_CNT_WD-1:0]  sh_new_cnt;
  logic [BYTE_CNT_WD-1:0]  sh_total;

  // Next values for the output registers.
  logic                    emit_out;
  logic [DATA_WD-1:0]      out_word_d;
  logic [DATA_BYTE_WD-1:0] out_keep_d;
  logic                    out_last_d;
  logic                    emit_hdr;
  logic [DATA_WD-1:0]      hdr_word_d;
  logic [DATA_BYTE_WD-1:0] hdr_keep_d;

  assign out_free = !valid_out || ready_out;
  assign hdr_free = !valid_hdr || ready_hdr;
  assign ready_in = !rst && out_free && hdr_free && (state_q != FLUSH);
  assign fire     = valid_in && ready_in;

  always_comb begin
    n_clamp      = (byte_remove_cnt > BEAT_BYTES) ? BEAT_BYTES : byte_remove_cnt;
    in_cnt       = keep2cnt(keep_in);
    in_masked    = data_in & keep2mask(keep_in);
    hdr_cnt      = (n_clamp < in_cnt) ? n_clamp : in_cnt;
    pay_cnt      = (in_cnt > n_clamp) ? (in_cnt - n_clamp) : '0;
    // Shifting by 4 bytes leaves nothing, which is exactly the N=4 case.
    head_shifted = in_masked << {n_clamp, 3'b000};
    hdr_word_d   = in_masked & keep2mask(cnt2keep(hdr_cnt));
    hdr_keep_d   = cnt2keep(hdr_cnt);
  end

  axi_stream_byte_shifter u_shifter (
    .res_data  (res_q),
    .res_cnt   (res_cnt_q),
    .beat_data (data_in),
    .beat_keep (keep_in),
    .out_word  (sh_word),
    .out_keep  (sh_keep),
    .new_res   (sh_res),
    .new_cnt   (sh_new_cnt),
    .total_cnt (sh_total)
  );

  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    res_cnt_d  = res_cnt_q;
    emit_out   = 1'b0;
    out_word_d = '0;
    out_keep_d = '0;
    out_last_d = 1'b0;
    emit_hdr   = 1'b0;

    unique case (state_q)
      HEAD: begin
        if (fire) begin
          emit_hdr = (hdr_cnt != '0);
          if (last_in) begin
            // Single-beat packet: whatever is left after the header goes out now.
            emit_out   = (pay_cnt != '0);
            out_word_d = head_shifted;
            out_keep_d = cnt2keep(pay_cnt);
            out_last_d = 1'b1;
            res_d      = '0;
            res_cnt_d  = '0;
          end else if (n_clamp == '0) begin
            emit_out   = 1'b1;
            out_word_d = data_in;
            out_keep_d = keep_in;
            res_d      = '0;
            res_cnt_d  = '0;
            state_d    = BODY;
          end else begin
            // Bytes after the header wait in the residue (none when N=4).
            res_d     = head_shifted[DATA_WD-1 -: RES_WD];
            res_cnt_d = BEAT_BYTES - n_clamp;
            state_d   = BODY;
          end
        end
      end

      BODY: begin
        if (fire) begin
          emit_out   = (sh_total != '0);
          out_word_d = sh_word;
          out_keep_d = sh_keep;
          if (last_in && (sh_total > BEAT_BYTES)) begin
            res_d     = sh_res;
            res_cnt_d = sh_new_cnt;
            state_d   = FLUSH;
          end else if (last_in) begin
            out_last_d = 1'b1;
            res_d      = '0;
            res_cnt_d  = '0;
            state_d    = HEAD;
          end else begin
            res_d     = sh_res;
            res_cnt_d = sh_new_cnt;
          end
        end
      end

      FLUSH: begin
        if (out_free) begin
          emit_out   = 1'b1;
          out_word_d = {res_q, {(DATA_WD - RES_WD){1'b0}}};
          out_keep_d = cnt2keep(res_cnt_q);
          out_last_d = 1'b1;
          res_d      = '0;
          res_cnt_d  = '0;
          state_d    = HEAD;
        end
      end

      default: state_d = HEAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HEAD;
      res_q     <= '0;
      res_cnt_q <= '0;
      valid_hdr <= 1'b0;
      data_hdr  <= '0;
      keep_hdr  <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      res_cnt_q <= res_cnt_d;

      // emit_* can only be set while the matching register is free.
      if (out_free) begin
        valid_out <= emit_out;
        if (emit_out) begin
          data_out <= out_word_d;
          keep_out <= out_keep_d;
          last_out <= out_last_d;
        end
      end

      if (hdr_free) begin
        valid_hdr <= emit_hdr;
        if (emit_hdr) begin
          data_hdr <= hdr_word_d;
          keep_hdr <= hdr_keep_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_remove_header.sv
module tb_axi_stream_remove_header;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic [2:0]  byte_remove_cnt = '0;
  logic        valid_hdr;
  logic [31:0] data_hdr;
  logic [3:0]  keep_hdr;
  logic        ready_hdr = 1'b1;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b1;

  int errors = 0;
  int checks = 0;

  beat_t exp_out[$];
  beat_t exp_hdr[$];
  beat_t got_out[$];
  beat_t got_hdr[$];

  bit model_on = 1'b1;
  bit ro_rand  = 1'b0;
  bit rh_rand  = 1'b0;
  bit ro_val   = 1'b1;
  bit rh_val   = 1'b1;

  axi_stream_remove_header dut (
    .clk             (clk),
    .rst             (rst),
    .valid_in        (valid_in),
    .data_in         (data_in),
    .keep_in         (keep_in),
    .last_in         (last_in),
    .ready_in        (ready_in),
    .byte_remove_cnt (byte_remove_cnt),
    .valid_hdr       (valid_hdr),
    .data_hdr        (data_hdr),
    .keep_hdr        (keep_hdr),
    .ready_hdr       (ready_hdr),
    .valid_out       (valid_out),
    .data_out        (data_out),
    .keep_out        (keep_out),
    .last_out        (last_out),
    .ready_out       (ready_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ones(input int c);
    logic [3:0] k;
    k = '0;
    for (int i = 0; i < c; i++) k[3-i] = 1'b1;
    return k;
  endfunction

  // Packet-level reference: header = first min(N, first-beat bytes) bytes,
  // payload = bytes N..L-1 chunked densely into 4-byte beats.
  function automatic void model_packet(input int n_raw, input byte_q_t pb);
    int    n;
    int    len;
    int    k0;
    int    h;
    beat_t b;
    n   = (n_raw > 4) ? 4 : n_raw;
    len = pb.size();
    k0  = (len < 4) ? len : 4;
    h   = (n < k0) ? n : k0;
    if (h > 0) begin
      b.d = '0;
      for (int i = 0; i < h; i++) b.d[31-8*i -: 8] = pb[i];
      b.k = ones(h);
      b.l = 1'b0;
      exp_hdr.push_back(b);
    end
    for (int s = n; s < len; s += 4) begin
      int c;
      c   = ((len - s) < 4) ? (len - s) : 4;
      b.d = '0;
      for (int i = 0; i < c; i++) b.d[31-8*i -: 8] = pb[s+i];
      b.k = ones(c);
      b.l = (s + 4 >= len);
      exp_out.push_back(b);
    end
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                           input logic [2:0] n);
    int t;
    bit acc;
    valid_in        = 1'b1;
    data_in         = d;
    keep_in         = k;
    last_in         = l;
    byte_remove_cnt = n;
    t   = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = ready_in;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 500);
    valid_in = 1'b0;
    if (!acc) chk("accept timeout", 64'(acc), 64'd1);
  endtask

  task automatic send_packet(input int n_raw, input byte_q_t pb, input bit garbage);
    int len;
    len = pb.size();
    if (model_on) model_packet(n_raw, pb);
    for (int b = 0; b * 4 < len; b++) begin
      logic [31:0] d;
      logic [3:0]  k;
      logic [2:0]  n;
      d = '0;
      k = '0;
      for (int i = 0; i < 4; i++) begin
        if (b * 4 + i < len) begin
          d[31-8*i -: 8] = pb[b*4+i];
          k[3-i]         = 1'b1;
        end else if (garbage) begin
          d[31-8*i -: 8] = 8'($urandom);
        end
      end
      // Only the first beat's count matters; later beats get noise.
      n = (b == 0) ? 3'(n_raw) : 3'($urandom_range(0, 7));
      send_beat(d, k, (b + 1) * 4 >= len, n);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_out.size() != 0 || exp_hdr.size() != 0) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk("drain pending beats", 64'(exp_out.size() + exp_hdr.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    ready_out = ro_rand ? ($urandom_range(0, 3) != 0) : ro_val;
    ready_hdr = rh_rand ? ($urandom_range(0, 2) != 0) : rh_val;
  end

  // Compare process: every handshake against the model, plus hold stability.
  logic        prev_out_stall = 1'b0;
  logic        prev_hdr_stall = 1'b0;
  logic [37:0] prev_out = '0;
  logic [36:0] prev_hdr = '0;
  beat_t       eo;
  beat_t       eh;

  always @(negedge clk) begin
    if (rst) begin
      prev_out_stall = 1'b0;
      prev_hdr_stall = 1'b0;
    end else begin
      if (prev_out_stall)
        chk("out hold while stalled", {26'd0, valid_out, data_out, keep_out, last_out},
            {26'd0, prev_out});
      if (prev_hdr_stall)
        chk("hdr hold while stalled", {27'd0, valid_hdr, data_hdr, keep_hdr},
            {27'd0, prev_hdr});
      chk("ready_in gated by free outputs",
          64'(ready_in && !((!valid_out || ready_out) && (!valid_hdr || ready_hdr))), 64'd0);

      if (valid_out && ready_out) begin
        eo.d = data_out;
        eo.k = keep_out;
        eo.l = last_out;
        got_out.push_back(eo);
        if (model_on) begin
          if (exp_out.size() == 0) begin
            chk("unexpected out beat", {32'd0, data_out}, 64'd0);
          end else begin
            eo = exp_out.pop_front();
            chk("out data", 64'(data_out), 64'(eo.d));
            chk("out keep", 64'(keep_out), 64'(eo.k));
            chk("out last", 64'(last_out), 64'(eo.l));
          end
        end
      end
      if (valid_hdr && ready_hdr) begin
        eh.d = data_hdr;
        eh.k = keep_hdr;
        eh.l = 1'b0;
        got_hdr.push_back(eh);
        if (model_on) begin
          if (exp_hdr.size() == 0) begin
            chk("unexpected hdr beat", {32'd0, data_hdr}, 64'd0);
          end else begin
            eh = exp_hdr.pop_front();
            chk("hdr data", 64'(data_hdr), 64'(eh.d));
            chk("hdr keep", 64'(keep_hdr), 64'(eh.k));
          end
        end
      end

      prev_out_stall = valid_out && !ready_out;
      prev_hdr_stall = valid_hdr && !ready_hdr;
      prev_out       = {valid_out, data_out, keep_out, last_out};
      prev_hdr       = {valid_hdr, data_hdr, keep_hdr};
    end
  end

  initial begin
    byte_q_t p;

    // Reset state.
    #1 rst = 1'b1;
    #1;
    chk("reset valid_out", 64'(valid_out), 64'd0);
    chk("reset valid_hdr", 64'(valid_hdr), 64'd0);
    chk("reset last_out", 64'(last_out), 64'd0);
    chk("reset data_out/keep_out", {28'd0, data_out, keep_out}, 64'd0);
    chk("reset data_hdr/keep_hdr", {28'd0, data_hdr, keep_hdr}, 64'd0);
    chk("reset ready_in", 64'(ready_in), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // N=2, no FLUSH.
    got_out.delete();
    got_hdr.delete();
    p = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hC1, 8'hC2};
    send_packet(2, p, 1'b0);
    drain();
    chk("tp N2 hdr count", 64'(got_hdr.size()), 64'd1);
    chk("tp N2 hdr", {28'd0, got_hdr[0].d, got_hdr[0].k}, {28'd0, 32'hA1A20000, 4'b1100});
    chk("tp N2 out count", 64'(got_out.size()), 64'd2);
    chk("tp N2 out0", {27'd0, got_out[0].d, got_out[0].k, got_out[0].l},
        {27'd0, 32'hA3A4B1B2, 4'b1111, 1'b0});
    chk("tp N2 out1", {27'd0, got_out[1].d, got_out[1].k, got_out[1].l},
        {27'd0, 32'hB3B4C1C2, 4'b1111, 1'b1});

    // N=1, ends in FLUSH with one input bubble.
    got_out.delete();
    got_hdr.delete();
    p = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hC1, 8'hC2, 8'hC3};
    send_packet(1, p, 1'b0);
    @(negedge clk);
    chk("flush bubble ready_in", 64'(ready_in), 64'd0);
    @(negedge clk);
    chk("after flush ready_in", 64'(ready_in), 64'd1);
    @(posedge clk);
    #1;
    drain();
    chk("tp N1 hdr", {28'd0, got_hdr[0].d, got_hdr[0].k}, {28'd0, 32'hA1000000, 4'b1000});
    chk("tp N1 out count", 64'(got_out.size()), 64'd3);
    chk("tp N1 out0", 64'(got_out[0].d), 64'h0A2A3A4B1);
    chk("tp N1 out1", 64'(got_out[1].d), 64'h0B2B3B4C1);
    chk("tp N1 out2", {27'd0, got_out[2].d, got_out[2].k, got_out[2].l},
        {27'd0, 32'hC2C30000, 4'b1100, 1'b1});

    // N=4 with the header consumer stalled, then the clamped N=7.
    got_out.delete();
    got_hdr.delete();
    rh_val = 1'b0;
    p = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_packet(4, p, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hdr stall ready_in", 64'(ready_in), 64'd0);
      chk("hdr stall valid_hdr", 64'(valid_hdr), 64'd1);
    end
    rh_val = 1'b1;
    @(posedge clk);
    #1;
    send_packet(7, p, 1'b0);
    drain();
    chk("tp N4 hdr count", 64'(got_hdr.size()), 64'd2);
    chk("tp N4 hdr", {28'd0, got_hdr[0].d, got_hdr[0].k}, {28'd0, 32'h11223344, 4'b1111});
    chk("tp N7 clamp hdr", {28'd0, got_hdr[1].d, got_hdr[1].k},
        {28'd0, 32'h11223344, 4'b1111});
    chk("tp N4 no payload", 64'(got_out.size()), 64'd0);

    // N=0 pass-through.
    got_out.delete();
    got_hdr.delete();
    p = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23, 8'hDE, 8'hAD};
    send_packet(0, p, 1'b0);
    drain();
    chk("tp N0 no hdr", 64'(got_hdr.size()), 64'd0);
    chk("tp N0 out count", 64'(got_out.size()), 64'd3);
    chk("tp N0 out0", 64'(got_out[0].d), 64'h010111213);
    chk("tp N0 last", {27'd0, got_out[2].d, got_out[2].k, got_out[2].l},
        {27'd0, 32'hDEAD0000, 4'b1100, 1'b1});

    // Payload backpressure mid-packet.
    p.delete();
    for (int i = 0; i < 22; i++) p.push_back(8'(8'h40 + i));
    fork
      send_packet(2, p, 1'b0);
      begin
        repeat (3) @(negedge clk);
        ro_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("bp ready_in", 64'(ready_in), 64'd0);
          chk("bp valid_out held", 64'(valid_out), 64'd1);
        end
        ro_val = 1'b1;
      end
    join
    drain();

    // Reset in BODY of an N=1 packet.
    model_on = 1'b0;
    send_beat(32'h55667788, 4'b1111, 1'b0, 3'd1);
    send_beat(32'h99AABBCC, 4'b1111, 1'b0, 3'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid reset valid_out", 64'(valid_out), 64'd0);
    chk("mid reset valid_hdr", 64'(valid_hdr), 64'd0);
    chk("mid reset ready_in", 64'(ready_in), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    exp_out.delete();
    exp_hdr.delete();
    got_out.delete();
    got_hdr.delete();
    model_on = 1'b1;
    p = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_packet(0, p, 1'b0);
    drain();
    chk("post reset hdr count", 64'(got_hdr.size()), 64'd0);
    chk("post reset out", {27'd0, got_out[0].d, got_out[0].k, got_out[0].l},
        {27'd0, 32'h01020304, 4'b1111, 1'b1});

    // Randomized packets with random backpressure on both consumers.
    ro_rand = 1'b1;
    rh_rand = 1'b1;
    for (int pk = 0; pk < 80; pk++) begin
      int len;
      len = $urandom_range(1, 14);
      p.delete();
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      send_packet($urandom_range(0, 7), p, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    ro_rand = 1'b0;
    rh_rand = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
